uart_tx_cfg: RTL and testbench

Parametrised UART transmitter that supersedes the fixed 8-bit/even-parity transmitter. It accepts words over a valid/ready stream into an internal FIFO and serialises them LSB-first. Frame format is set at elaboration: data width, parity mode, stop-bit count. The bit-rate divider is internal, so no external baud generator is needed. It sits between a system-side producer (register block or DMA) and the board TX pin.

---
 rtl/uart_tx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: valid/ready input into a small FIFO, LSB-first serialiser
// with internal bit-rate divider. Data width, parity and stop-bit count are fixed at elaboration.
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    // state  | meaning
    // IDLE   | line high, waiting for a queued word
    // START  | start bit (low), one bit time
    // DATA   | DATA_BITS data bits, LSB first
    // PARITY | parity bit, skipped when PARITY_MODE = 0
    // STOP   | STOP_BITS stop bits (high); pops the next word on the last cycle

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] pop_data;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 par;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;
    logic                 tx_next;

    // in_ready looks only at the registered level, so a pop never opens a slot in the same cycle
    assign in_ready   = (level != LVL_W'(FIFO_DEPTH));
    assign fifo_level = level;
    assign push       = in_valid && in_ready;
    assign pop_data   = mem[rd_ptr];
    assign bit_end    = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_end   = bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign pop        = (level != '0) && ((state == ST_IDLE) || ((state == ST_STOP) && stop_end));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift[0];
            ST_PARITY: tx_next = par;
            default:   tx_next = 1'b1;
        endcase
    end

    // Pin outputs are registered from the state, so they trail the state by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_next;
            busy    <= (state != ST_IDLE);
            tx_done <= (state == ST_STOP) && stop_end;
            cnt     <= bit_end ? '0 : cnt + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        shift   <= pop_data;
                        par     <= (^pop_data) ^ (PARITY_MODE == 2);
                        bit_cnt <= '0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_end) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shift <= pop_data;
                                par   <= (^pop_data) ^ (PARITY_MODE == 2);
                                state <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three frame formats checked from a vector table, plus sequences for
// FIFO full/back-to-back, push/pop on the same edge, and reset mid-frame.
module tb_uart_tx_cfg;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_a = '0;
    logic [6:0] din_b = '0;
    logic [4:0] din_c = '0;
    logic       vld_a = 1'b0, vld_b = 1'b0, vld_c = 1'b0;
    logic       rdy_a, rdy_b, rdy_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [2:0] lvl_a, lvl_b, lvl_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         nbits;
        logic [15:0] exp;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] full_words [6];
    logic [7:0] sim_words [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 8 data, even parity, 1 stop. B: 7 data, odd parity, 2 stop. C: 5 data, no parity, 1 stop.
    uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in_data(din_a), .in_valid(vld_a), .in_ready(rdy_a),
        .tx(tx_a), .busy(busy_a), .tx_done(done_a), .fifo_level(lvl_a));
    uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(din_b), .in_valid(vld_b), .in_ready(rdy_b),
        .tx(tx_b), .busy(busy_b), .tx_done(done_b), .fifo_level(lvl_b));
    uart_tx_cfg #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .in_data(din_c), .in_valid(vld_c), .in_ready(rdy_c),
        .tx(tx_c), .busy(busy_c), .tx_done(done_c), .fifo_level(lvl_c));

    function automatic logic get_tx(input int inst);
        case (inst)
            0: return tx_a;
            1: return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_done(input int inst);
        case (inst)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_rdy(input int inst);
        case (inst)
            0: return rdy_a;
            1: return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic int get_lvl(input int inst);
        case (inst)
            0: return int'(lvl_a);
            1: return int'(lvl_b);
            default: return int'(lvl_c);
        endcase
    endfunction

    task automatic drive(input int inst, input logic [7:0] d, input logic v);
        case (inst)
            0: begin din_a = d; vld_a = v; end
            1: begin din_b = d[6:0]; vld_b = v; end
            default: begin din_c = d[4:0]; vld_c = v; end
        endcase
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Push one word into an idle DUT and check latency, every tx cycle, tx_done and busy.
    task automatic send_and_check(input int inst, input logic [7:0] data, input int nbits,
                                  input logic [15:0] exp);
        int   lat;
        int   flen;
        int   bad_tx;
        int   bad_done;
        int   bad_busy;
        logic exp_tx;
        lat = -1; bad_tx = 0; bad_done = 0; bad_busy = 0;
        @(negedge clk); drive(inst, data, 1'b1);
        @(posedge clk); #1; drive(inst, 8'h00, 1'b0);
        for (int g = 1; g <= 20; g++) begin
            @(posedge clk); #1;
            if (get_tx(inst) == 1'b0) begin
                lat = g;
                break;
            end
        end
        check($sformatf("latency inst%0d data %02h", inst, data), lat, 2);
        if (lat < 0) return;
        flen = nbits * CPB;
        for (int c = 0; c <= flen; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            exp_tx = (c < flen) ? exp[c / CPB] : 1'b1;
            if (get_tx(inst) !== exp_tx) bad_tx++;
            if (get_done(inst) !== (c == flen - 1)) bad_done++;
            if (get_busy(inst) !== (c < flen)) bad_busy++;
        end
        check($sformatf("tx bit errors inst%0d data %02h", inst, data), bad_tx, 0);
        check($sformatf("tx_done errors inst%0d data %02h", inst, data), bad_done, 0);
        check($sformatf("busy errors inst%0d data %02h", inst, data), bad_busy, 0);
    endtask

    // Receive one frame on instance A; returns 41 cycles after the start-bit fall.
    task automatic rx_frame(output logic [7:0] d, output int fall, output bit ok);
        ok = 1'b0; d = '0; fall = 0;
        for (int g = 0; g < 400; g++) begin
            if (tx_a == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) return;
        fall = cyc;
        repeat (CPB + CPB / 2) @(posedge clk);
        #1;
        d[0] = tx_a;
        for (int k = 1; k < 8; k++) begin
            repeat (CPB) @(posedge clk);
            #1;
            d[k] = tx_a;
        end
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(negedge clk); drive(0, a, 1'b1);
        @(negedge clk); drive(0, b, 1'b1);
        @(negedge clk); drive(0, c, 1'b1);
        @(negedge clk); drive(0, 8'h00, 1'b0);
    endtask

    task automatic full_driver();
        int   k;
        int   g;
        int   first_refuse;
        int   full_lvl;
        logic acc;
        k = 0; g = 0; first_refuse = -1; full_lvl = -1;
        @(negedge clk); drive(0, full_words[0], 1'b1);
        while (k < 6 && g < 1000) begin
            g++;
            acc = rdy_a;
            if (!acc && first_refuse < 0) begin
                first_refuse = k;
                full_lvl = int'(lvl_a);
            end
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 6) drive(0, full_words[k], 1'b1);
            end
        end
        drive(0, 8'h00, 1'b0);
        check("pushes before in_ready drop", first_refuse, 5);
        check("level when in_ready drops", full_lvl, 4);
        check("words accepted", k, 6);
    endtask

    task automatic full_receiver();
        logic [7:0] d;
        int         f;
        int         prev;
        bit         ok;
        prev = 0;
        for (int j = 0; j < 6; j++) begin
            rx_frame(d, f, ok);
            check($sformatf("full frame %0d found", j), int'(ok), 1);
            if (!ok) return;
            check($sformatf("full frame %0d data", j), int'(d), int'(full_words[j]));
            if (j > 0) check($sformatf("full frame %0d spacing", j), f - prev, 4 * 11);
            prev = f;
        end
    endtask

    task automatic simul_test();
        logic [7:0] d;
        int         f;
        int         prev;
        bit         ok;
        push3(sim_words[0], sim_words[1], sim_words[2]);
        rx_frame(d, f, ok);
        check("simul frame 0 found", int'(ok), 1);
        if (!ok) return;
        check("simul frame 0 data", int'(d), int'(sim_words[0]));
        @(posedge clk);
        @(negedge clk);
        check("level before pop edge", int'(lvl_a), 2);
        drive(0, sim_words[3], 1'b1);
        @(posedge clk); #1;
        drive(0, 8'h00, 1'b0);
        check("tx_done on pop edge", int'(done_a), 1);
        check("level after push+pop", int'(lvl_a), 2);
        prev = f;
        for (int j = 1; j < 4; j++) begin
            rx_frame(d, f, ok);
            check($sformatf("simul frame %0d found", j), int'(ok), 1);
            if (!ok) return;
            check($sformatf("simul frame %0d data", j), int'(d), int'(sim_words[j]));
            check($sformatf("simul frame %0d spacing", j), f - prev, 4 * 11);
            prev = f;
        end
    endtask

    task automatic reset_test();
        int quiet;
        push3(8'h96, 8'h3C, 8'h81);
        repeat (8) @(posedge clk);
        #3;
        check("busy before reset", int'(busy_a), 1);
        rst = 1'b1;
        #1;
        check("tx during reset", int'(tx_a), 1);
        check("busy during reset", int'(busy_a), 0);
        check("level during reset", int'(lvl_a), 0);
        check("in_ready during reset", int'(rdy_a), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || lvl_a != 3'd0) quiet++;
        end
        check("activity after reset release", quiet, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected frames, bit k = line value in bit time k (start, data LSB first, parity, stop)
        vecs[0] = '{inst: 0, data: 8'hA5, nbits: 11, exp: 16'h054A}; // 101_0100_1010
        vecs[1] = '{inst: 0, data: 8'h00, nbits: 11, exp: 16'h0400};
        vecs[2] = '{inst: 0, data: 8'hFF, nbits: 11, exp: 16'h05FE};
        vecs[3] = '{inst: 0, data: 8'h01, nbits: 11, exp: 16'h0602};
        vecs[4] = '{inst: 1, data: 8'h7F, nbits: 11, exp: 16'h06FE};
        vecs[5] = '{inst: 1, data: 8'h00, nbits: 11, exp: 16'h0700};
        vecs[6] = '{inst: 1, data: 8'h55, nbits: 11, exp: 16'h07AA};
        vecs[7] = '{inst: 2, data: 8'h13, nbits: 7,  exp: 16'h0066}; // 110_0110
        vecs[8] = '{inst: 2, data: 8'h1F, nbits: 7,  exp: 16'h007E};
        full_words = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h5A, 8'hF0};
        sim_words  = '{8'hB2, 8'h4D, 8'h07, 8'hE8};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset tx inst%0d", i), int'(get_tx(i)), 1);
            check($sformatf("reset busy inst%0d", i), int'(get_busy(i)), 0);
            check($sformatf("reset tx_done inst%0d", i), int'(get_done(i)), 0);
            check($sformatf("reset in_ready inst%0d", i), int'(get_rdy(i)), 1);
            check($sformatf("reset level inst%0d", i), get_lvl(i), 0);
        end

        for (int i = 0; i < 9; i++) begin
            send_and_check(vecs[i].inst, vecs[i].data, vecs[i].nbits, vecs[i].exp);
        end

        fork
            full_driver();
            full_receiver();
        join
        repeat (10) @(posedge clk);
        #1;
        check("level after full test", int'(lvl_a), 0);
        check("busy after full test", int'(busy_a), 0);

        simul_test();
        repeat (10) @(posedge clk);
        #1;
        check("level after simul test", int'(lvl_a), 0);

        reset_test();
        send_and_check(vecs[0].inst, vecs[0].data, vecs[0].nbits, vecs[0].exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
